// File: rtl/coord_pkg.sv
// Shared pixel-coordinate types and the linear-index helper used by the stream joiner.
package coord_pkg;

    localparam int IDX_W = 32;

    typedef logic [15:0] coord_t;

    typedef struct packed {
        coord_t col;
        coord_t row;
    } coord_pair_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_JOIN,
        ARB_DROP_A,
        ARB_DROP_B
    } arb_t;

    function automatic logic [IDX_W-1:0] lin_idx(input coord_pair_t pos,
                                                 input logic [IDX_W-1:0] width);
        return IDX_W'(pos.row) * width + IDX_W'(pos.col);
    endfunction

endpackage

// File: rtl/coord_fifo.sv
// Synchronous FIFO with a combinational head view.
// A write to a full FIFO is accepted only if the same cycle pops.
module coord_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = i_rd_en && !o_empty;
    assign w_push     = i_wr_en && (!w_full || w_pop);
    assign o_overflow = i_wr_en && !w_push;
    assign o_head     = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/stream_coord_joiner.sv
// Joins two valid-only pixel streams on matching (col,row), discarding the stream head
// that lags behind the other, with frame wrap-around resolved by modular distance.
module stream_coord_joiner
    import coord_pkg::*;
#(
    parameter int DATA_WIDTH_A = 16,
    parameter int DATA_WIDTH_B = 16,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH_A-1:0] a_data_i,
    input  logic [15:0]             a_col_i,
    input  logic [15:0]             a_row_i,
    input  logic                    a_valid_i,
    input  logic [DATA_WIDTH_B-1:0] b_data_i,
    input  logic [15:0]             b_col_i,
    input  logic [15:0]             b_row_i,
    input  logic                    b_valid_i,
    output logic [DATA_WIDTH_A-1:0] a_data_o,
    output logic [DATA_WIDTH_B-1:0] b_data_o,
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o,
    output logic                    drop_a_o,
    output logic                    drop_b_o,
    output logic                    overflow_o
);

    localparam int PW  = $bits(coord_pair_t);
    localparam int A_W = DATA_WIDTH_A + PW;
    localparam int B_W = DATA_WIDTH_B + PW;
    localparam logic [IDX_W-1:0] ROW_LEN = IDX_W'(IMAGE_WIDTH);
    localparam logic [IDX_W-1:0] FRAME   = IDX_W'(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam logic [IDX_W-1:0] HALF    = FRAME >> 1;

    logic [A_W-1:0]          w_a_head;
    logic [B_W-1:0]          w_b_head;
    logic                    w_a_empty;
    logic                    w_b_empty;
    logic                    w_a_ovf;
    logic                    w_b_ovf;
    logic                    w_pop_a;
    logic                    w_pop_b;
    coord_pair_t             w_a_pos;
    coord_pair_t             w_b_pos;
    logic [IDX_W-1:0]        w_idx_a;
    logic [IDX_W-1:0]        w_idx_b;
    logic [IDX_W-1:0]        w_diff;
    arb_t                    w_arb;

    logic                    r_valid;
    logic                    r_drop_a;
    logic                    r_drop_b;
    logic                    r_overflow;
    logic [DATA_WIDTH_A-1:0] r_a_data;
    logic [DATA_WIDTH_B-1:0] r_b_data;
    coord_pair_t             r_pos;

    coord_fifo #(
        .WIDTH (A_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_wr_en    (a_valid_i),
        .i_wr_data  ({a_data_i, a_col_i, a_row_i}),
        .i_rd_en    (w_pop_a),
        .o_head     (w_a_head),
        .o_empty    (w_a_empty),
        .o_overflow (w_a_ovf)
    );

    coord_fifo #(
        .WIDTH (B_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_wr_en    (b_valid_i),
        .i_wr_data  ({b_data_i, b_col_i, b_row_i}),
        .i_rd_en    (w_pop_b),
        .o_head     (w_b_head),
        .o_empty    (w_b_empty),
        .o_overflow (w_b_ovf)
    );

    assign w_a_pos = coord_pair_t'(w_a_head[PW-1:0]);
    assign w_b_pos = coord_pair_t'(w_b_head[PW-1:0]);
    assign w_idx_a = lin_idx(w_a_pos, ROW_LEN);
    assign w_idx_b = lin_idx(w_b_pos, ROW_LEN);

    // Modular distance A-B over one frame: under half a frame means A is ahead.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_arb  = ARB_IDLE;
        w_diff = '0;
        if (!w_a_empty && !w_b_empty) begin
            if (w_idx_a == w_idx_b) begin
                w_arb = ARB_JOIN;
            end else begin
                w_diff = (w_idx_a >= w_idx_b) ? (w_idx_a - w_idx_b)
                                              : (w_idx_a + FRAME - w_idx_b);
                w_arb  = (w_diff < HALF) ? ARB_DROP_B : ARB_DROP_A;
            end
        end
    end

    assign w_pop_a = (w_arb == ARB_JOIN) || (w_arb == ARB_DROP_A);
    assign w_pop_b = (w_arb == ARB_JOIN) || (w_arb == ARB_DROP_B);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_drop_a   <= 1'b0;
            r_drop_b   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid  <= (w_arb == ARB_JOIN);
            r_drop_a <= (w_arb == ARB_DROP_A);
            r_drop_b <= (w_arb == ARB_DROP_B);
            if (w_a_ovf || w_b_ovf) r_overflow <= 1'b1;
        end
    end

    // Payload and coordinates only load on a join and otherwise hold.
    always_ff @(posedge clk_i) begin
        if (w_arb == ARB_JOIN) begin
            r_a_data <= w_a_head[A_W-1:PW];
            r_b_data <= w_b_head[B_W-1:PW];
            r_pos    <= w_a_pos;
        end
    end

    assign valid_o    = r_valid;
    assign drop_a_o   = r_drop_a;
    assign drop_b_o   = r_drop_b;
    assign overflow_o = r_overflow;
    assign a_data_o   = r_a_data;
    assign b_data_o   = r_b_data;
    assign col_o      = r_pos.col;
    assign row_o      = r_pos.row;

endmodule
